// File: rtl/handshake_broadcaster_pkg.sv
// Shared constants for the handshake broadcaster: throughput mode names and
// the helper that maps a mode string onto full-throughput operation.
package handshake_broadcaster_pkg;

    localparam string BURST_YES = "yes";
    localparam string BURST_NO  = "no";

    // Only an explicit "no" selects half throughput; anything else streams.
    function automatic bit burst_enabled(string mode);
        return mode != BURST_NO;
    endfunction

endpackage

// File: rtl/handshake_broadcaster_if.sv
// Valid/ready/data bundle for one handshake port of the broadcaster.
interface handshake_broadcaster_if #(
    parameter int WIDTH = 8
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/handshake_broadcaster_bcast_slot.sv
// One output register slot of the broadcaster: holds a word until its consumer
// takes it and reports whether it can accept the next one.
module bcast_slot
    import handshake_broadcaster_pkg::*;
#(
    parameter int    WIDTH = 8,
    parameter string BURST = BURST_YES
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             can
);

    localparam bit BURST_EN = burst_enabled(BURST);

    // In burst mode a slot being drained this cycle can reload at the same edge.
    assign can = BURST_EN ? (!valid || ready) : !valid;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= data_in;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/handshake_broadcaster.sv
// One-to-two valid/ready fork: each accepted word is split into a low field for
// bm0 and a high field for bm1, each delivered once through its own register slot.
module handshake_broadcaster
    import handshake_broadcaster_pkg::*;
#(
    parameter int    WIDTH0 = 8,
    parameter int    WIDTH1 = 8,
    parameter string BURST  = BURST_YES
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    handshake_broadcaster_if.slave  am,
    handshake_broadcaster_if.master bm0,
    handshake_broadcaster_if.master bm1
);

    logic can0;
    logic can1;
    logic accept;

    // Ready depends only on slot state and consumer readies, never on am.valid.
    assign am.ready = can0 && can1;
    assign accept   = am.valid && can0 && can1;

    bcast_slot #(.WIDTH(WIDTH0), .BURST(BURST)) u_slot0 (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .load    (accept),
        .data_in (am.data[WIDTH0-1:0]),
        .ready   (bm0.ready),
        .valid   (bm0.valid),
        .data    (bm0.data),
        .can     (can0)
    );

    bcast_slot #(.WIDTH(WIDTH1), .BURST(BURST)) u_slot1 (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .load    (accept),
        .data_in (am.data[WIDTH0+WIDTH1-1:WIDTH0]),
        .ready   (bm1.ready),
        .valid   (bm1.valid),
        .data    (bm1.data),
        .can     (can1)
    );

endmodule

// File: tb/tb_handshake_broadcaster.sv
// Randomised bench for handshake_broadcaster: a burst and a half-throughput
// instance checked cycle by cycle against a held-word model and stream scoreboards.
module tb_handshake_broadcaster;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // index 0: BURST="yes" instance, index 1: BURST="no" instance
    logic        vin [2];
    logic [11:0] din [2];
    logic        r0  [2];
    logic        r1  [2];

    handshake_broadcaster_if #(.WIDTH(12)) am_y ();
    handshake_broadcaster_if #(.WIDTH(8))  b0_y ();
    handshake_broadcaster_if #(.WIDTH(4))  b1_y ();
    handshake_broadcaster_if #(.WIDTH(12)) am_n ();
    handshake_broadcaster_if #(.WIDTH(8))  b0_n ();
    handshake_broadcaster_if #(.WIDTH(4))  b1_n ();

    assign am_y.valid = vin[0];
    assign am_y.data  = din[0];
    assign b0_y.ready = r0[0];
    assign b1_y.ready = r1[0];
    assign am_n.valid = vin[1];
    assign am_n.data  = din[1];
    assign b0_n.ready = r0[1];
    assign b1_n.ready = r1[1];

    handshake_broadcaster #(.WIDTH0(8), .WIDTH1(4), .BURST("yes")) dut_y (
        .iCLK (clk), .iRST (rst), .am (am_y), .bm0 (b0_y), .bm1 (b1_y)
    );

    handshake_broadcaster #(.WIDTH0(8), .WIDTH1(4), .BURST("no")) dut_n (
        .iCLK (clk), .iRST (rst), .am (am_n), .bm0 (b0_n), .bm1 (b1_n)
    );

    int checks = 0;
    int errors = 0;

    // Model: which branches hold an undelivered word, and the last word loaded.
    bit          mfull [2][2];
    logic [7:0]  mdat0 [2];
    logic [3:0]  mdat1 [2];
    logic [11:0] sent  [2][$];
    logic [7:0]  got0  [2][$];
    logic [3:0]  got1  [2][$];

    // {ready, valid0, data0, valid1, data1}
    function automatic logic [14:0] obs_vec(int d);
        if (d == 0) return {am_y.ready, b0_y.valid, b0_y.data, b1_y.valid, b1_y.data};
        return {am_n.ready, b0_n.valid, b0_n.data, b1_n.valid, b1_n.data};
    endfunction

    function automatic bit exp_ready(int d);
        bit burst = (d == 0);
        return (!mfull[d][0] || (burst && r0[d])) && (!mfull[d][1] || (burst && r1[d]));
    endfunction

    function automatic logic [14:0] exp_vec(int d);
        return {exp_ready(d), mfull[d][0], mdat0[d], mfull[d][1], mdat1[d]};
    endfunction

    // Called at the negedge: logs DUT deliveries, steps the model, crosses the edge.
    task automatic advance();
        for (int d = 0; d < 2; d++) begin
            logic [14:0] o;
            bit          acc;
            o   = obs_vec(d);
            acc = vin[d] && exp_ready(d);
            if (rst) begin
                mfull[d][0] = 1'b0;
                mfull[d][1] = 1'b0;
                mdat0[d]    = '0;
                mdat1[d]    = '0;
            end else begin
                if (o[13] === 1'b1 && r0[d]) got0[d].push_back(o[12:5]);
                if (o[4] === 1'b1 && r1[d])  got1[d].push_back(o[3:0]);
                if (acc) begin
                    mfull[d][0] = 1'b1;
                    mfull[d][1] = 1'b1;
                    mdat0[d]    = din[d][7:0];
                    mdat1[d]    = din[d][11:8];
                    sent[d].push_back(din[d]);
                end else begin
                    if (mfull[d][0] && r0[d]) mfull[d][0] = 1'b0;
                    if (mfull[d][1] && r1[d]) mfull[d][1] = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        for (int d = 0; d < 2; d++) begin
            sent[d].delete();
            got0[d].delete();
            got1[d].delete();
        end
    endtask

    task automatic idle_drain(int n);
        for (int d = 0; d < 2; d++) begin
            vin[d] = 1'b0;
            r0[d]  = 1'b1;
            r1[d]  = 1'b1;
        end
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            advance();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            vin[d] = 1'b1;
            din[d] = 12'($urandom);
            r0[d]  = 1'b1;
            r1[d]  = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            advance();
        end
        @(negedge clk);
        checks++;
        if (obs_vec(0) !== 15'h4000) begin
            errors++;
            $display("FAIL reset_state_y obs=%h exp=%h", obs_vec(0), 15'h4000);
        end
        checks++;
        if (obs_vec(1) !== 15'h4000) begin
            errors++;
            $display("FAIL reset_state_n obs=%h exp=%h", obs_vec(1), 15'h4000);
        end
        advance();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (am_y.ready !== 1'b1 || am_n.ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_after obs=%b%b exp=11", am_y.ready, am_n.ready);
        end
        advance();
        idle_drain(3);
    endtask

    task automatic test_single();
        idle_drain(2);
        vin[0] = 1'b1;
        din[0] = 12'hA5C;
        @(negedge clk);
        checks++;
        if (obs_vec(0) !== exp_vec(0)) begin
            errors++;
            $display("FAIL single_accept obs=%h exp=%h", obs_vec(0), exp_vec(0));
        end
        advance();
        vin[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (obs_vec(0) !== {1'b1, 1'b1, 8'h5C, 1'b1, 4'hA}) begin
            errors++;
            $display("FAIL single_deliver obs=%h exp=%h", obs_vec(0), {1'b1, 1'b1, 8'h5C, 1'b1, 4'hA});
        end
        advance();
        @(negedge clk);
        checks++;
        if (obs_vec(0) !== {1'b1, 1'b0, 8'h5C, 1'b0, 4'hA}) begin
            errors++;
            $display("FAIL single_drop obs=%h exp=%h", obs_vec(0), {1'b1, 1'b0, 8'h5C, 1'b0, 4'hA});
        end
        advance();
    endtask

    task automatic test_stream();
        bit bad = 1'b0;
        idle_drain(2);
        clear_logs();
        for (int i = 1; i <= 16; i++) begin
            vin[0] = 1'b1;
            din[0] = 12'(i);
            @(negedge clk);
            checks++;
            if (am_y.ready !== 1'b1 || obs_vec(0) !== exp_vec(0)) begin
                errors++;
                $display("FAIL stream_cycle%0d obs=%h exp=%h", i, obs_vec(0), exp_vec(0));
            end
            advance();
        end
        idle_drain(3);
        if (got0[0].size() != 16 || got1[0].size() != 16) bad = 1'b1;
        else
            for (int i = 0; i < 16; i++)
                if (got0[0][i] !== 8'(i + 1) || got1[0][i] !== 4'h0) bad = 1'b1;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL stream_order got0=%0d got1=%0d words exp=16 in order 1..16",
                     got0[0].size(), got1[0].size());
        end
    endtask

    task automatic test_stall();
        logic [11:0] w;
        logic [11:0] w2;
        w  = 12'($urandom);
        w2 = 12'($urandom);
        idle_drain(2);
        clear_logs();
        vin[0] = 1'b1;
        din[0] = w;
        @(negedge clk);
        advance();
        din[0] = w2;
        r1[0]  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (am_y.ready !== 1'b0 || b1_y.valid !== 1'b1 || b1_y.data !== w[11:8]
                || obs_vec(0) !== exp_vec(0)) begin
                errors++;
                $display("FAIL stall_cycle%0d obs=%h exp=%h", i, obs_vec(0), exp_vec(0));
            end
            advance();
        end
        r1[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (obs_vec(0) !== exp_vec(0)) begin
            errors++;
            $display("FAIL stall_release obs=%h exp=%h", obs_vec(0), exp_vec(0));
        end
        advance();
        idle_drain(3);
        checks++;
        if (got0[0].size() != 2 || got1[0].size() != 2 || got0[0][0] !== w[7:0]
            || got0[0][1] !== w2[7:0] || got1[0][0] !== w[11:8] || got1[0][1] !== w2[11:8]) begin
            errors++;
            $display("FAIL stall_words got0=%0d got1=%0d exp 2 each (%h then %h)",
                     got0[0].size(), got1[0].size(), w, w2);
        end
    endtask

    task automatic test_burst_no();
        logic [11:0] words [4];
        logic [7:0]  rdy_seq;
        int          cyc = 0;
        bit          bad = 1'b0;
        idle_drain(2);
        clear_logs();
        for (int i = 0; i < 4; i++) words[i] = 12'($urandom);
        rdy_seq = '0;
        while (sent[1].size() < 4 && cyc < 20) begin
            vin[1] = 1'b1;
            din[1] = words[sent[1].size()];
            @(negedge clk);
            if (cyc < 8) rdy_seq[cyc] = am_n.ready;
            checks++;
            if (obs_vec(1) !== exp_vec(1)) begin
                errors++;
                $display("FAIL nob_cycle%0d obs=%h exp=%h", cyc, obs_vec(1), exp_vec(1));
            end
            advance();
            cyc++;
        end
        idle_drain(3);
        checks++;
        if (cyc != 7 || rdy_seq[6:0] !== 7'b1010101) begin
            errors++;
            $display("FAIL nob_rate cycles=%0d ready_seq=%b exp cycles=7 seq=1010101", cyc, rdy_seq[6:0]);
        end
        if (got0[1].size() != 4 || got1[1].size() != 4) bad = 1'b1;
        else
            for (int i = 0; i < 4; i++)
                if (got0[1][i] !== words[i][7:0] || got1[1][i] !== words[i][11:8]) bad = 1'b1;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL nob_words got0=%0d got1=%0d exp 4 each in order", got0[1].size(), got1[1].size());
        end
    endtask

    task automatic test_reset_flush();
        idle_drain(2);
        clear_logs();
        vin[0] = 1'b1;
        din[0] = 12'($urandom);
        r0[0]  = 1'b0;
        r1[0]  = 1'b0;
        @(negedge clk);
        advance();
        vin[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (b0_y.valid !== 1'b1 || b1_y.valid !== 1'b1 || obs_vec(0) !== exp_vec(0)) begin
            errors++;
            $display("FAIL flush_full obs=%h exp=%h", obs_vec(0), exp_vec(0));
        end
        advance();
        rst   = 1'b1;
        r0[0] = 1'b1;
        r1[0] = 1'b1;
        @(negedge clk);
        advance();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (obs_vec(0) !== 15'h4000) begin
            errors++;
            $display("FAIL flush_cleared obs=%h exp=%h", obs_vec(0), 15'h4000);
        end
        advance();
        idle_drain(3);
        checks++;
        if (got0[0].size() != 0 || got1[0].size() != 0) begin
            errors++;
            $display("FAIL flush_no_delivery got0=%0d got1=%0d exp 0", got0[0].size(), got1[0].size());
        end
    endtask

    task automatic test_random();
        int cyc_err = 0;
        bit bad     = 1'b0;
        idle_drain(2);
        clear_logs();
        for (int i = 0; i < 400; i++) begin
            for (int d = 0; d < 2; d++) begin
                vin[d] = ($urandom_range(99) < 60);
                din[d] = 12'($urandom);
                r0[d]  = ($urandom_range(99) < 70);
                r1[d]  = ($urandom_range(99) < 70);
            end
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    errors++;
                    cyc_err++;
                    if (cyc_err <= 5)
                        $display("FAIL random_cycle%0d dut%0d obs=%h exp=%h", i, d, obs_vec(d), exp_vec(d));
                end
            end
            advance();
        end
        idle_drain(4);
        for (int d = 0; d < 2; d++) begin
            bad = 1'b0;
            if (got0[d].size() != sent[d].size() || got1[d].size() != sent[d].size()) bad = 1'b1;
            else
                for (int i = 0; i < sent[d].size(); i++)
                    if (got0[d][i] !== sent[d][i][7:0] || got1[d][i] !== sent[d][i][11:8]) bad = 1'b1;
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL random_scoreboard dut%0d got0=%0d got1=%0d sent=%0d",
                         d, got0[d].size(), got1[d].size(), sent[d].size());
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            vin[d] = 1'b0;
            din[d] = '0;
            r0[d]  = 1'b1;
            r1[d]  = 1'b1;
            mfull[d][0] = 1'b0;
            mfull[d][1] = 1'b0;
            mdat0[d] = '0;
            mdat1[d] = '0;
        end
        #1;
        test_reset();
        test_single();
        test_stream();
        test_stall();
        test_burst_no();
        test_reset_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
